// File: rtl/fifo_bit_reader.sv
// fifo_bit_reader
// ---------------
// Drain side of the single-bit FIFO in the USB3300 sniffer. The block pops
// one bit at a time from the FIFO while it is non-empty and not busy. It
// packs WIDTH bits LSB-first (the first bit popped lands in O_DATA[0]) and
// offers the finished word downstream on a valid/ready handshake.
//
// Optional feature (compile-time macro FIFO_READER_FLUSH_EN):
//   If the macro is defined, a partial word is emitted after FLUSH_CYCLES
//   consecutive empty cycles in IDLE. That word has o_partial=1 and
//   o_nbits = number of captured bits. If the macro is undefined, no flush
//   counter is built, o_partial is tied to 0, and a partial word waits
//   indefinitely.
//
// Ports:
//   clk        in   system clock, all state on the rising edge
//   reset      in   synchronous active-high reset
//   I_BIT      in   FIFO read data (valid POP_LAT cycles after the pop)
//   empty      in   FIFO empty flag
//   busy       in   FIFO busy flag
//   pop        out  one-cycle pop request to the FIFO
//   O_DATA     out  assembled word
//   o_valid    out  O_DATA is valid (registered)
//   i_ready    in   downstream accepts the word
//   o_partial  out  word is short (flush only)
//   o_nbits    out  number of valid bits in O_DATA
module fifo_bit_reader #(
  parameter int WIDTH        = 8,
  parameter int POP_LAT      = 2,
  parameter int FLUSH_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         I_BIT,
  input  logic                         empty,
  input  logic                         busy,
  output logic                         pop,
  output logic [WIDTH-1:0]             O_DATA,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic                         o_partial,
  output logic [$clog2(WIDTH+1)-1:0]   o_nbits
);

  localparam int NB = $clog2(WIDTH + 1);
  localparam int LW = $clog2(POP_LAT + 1);

  typedef enum logic [1:0] {IDLE, POP, WAIT, VALID} state_t;

  state_t           state_q, state_d;
  logic [NB-1:0]    bitcnt_q, bitcnt_d;
  logic [LW-1:0]    lat_q, lat_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [NB-1:0]    nbits_q, nbits_d;
  logic             pop_req;
  logic             lat_done;
  logic [WIDTH-1:0] bit_sel;

`ifdef FIFO_READER_FLUSH_EN
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  logic [FW-1:0]    flush_q, flush_d;
  logic             partial_q, partial_d;
`endif

  // One-hot decode of the bit position the next captured bit goes to.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sel
    assign bit_sel[gi] = (bitcnt_q == NB'(gi));
  end

  // lat_q counts WAIT cycles already spent. The current WAIT cycle is the
  // POP_LAT-th one when lat_q reaches POP_LAT-1. From then on the counter
  // saturates while busy holds the capture off.
  assign lat_done = (lat_q >= LW'(POP_LAT - 1));

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    lat_d    = lat_q;
    data_d   = data_q;
    nbits_d  = nbits_q;
    pop_req  = 1'b0;
`ifdef FIFO_READER_FLUSH_EN
    flush_d   = '0;
    partial_d = partial_q;
`endif
    case (state_q)
      IDLE: begin
        if (!empty && !busy) begin
          state_d = POP;
        end
`ifdef FIFO_READER_FLUSH_EN
        else if (empty && (bitcnt_q != '0)) begin
          if (flush_q == FW'(FLUSH_CYCLES - 1)) begin
            // Upper bits are already zero because the word is cleared on
            // every transfer.
            state_d   = VALID;
            partial_d = 1'b1;
            nbits_d   = bitcnt_q;
          end else begin
            flush_d = flush_q + FW'(1);
          end
        end
`endif
      end
      POP: begin
        // Re-check the flags so that pop can never coincide with empty or
        // busy, even if the flags moved since IDLE sampled them.
        if (empty || busy) begin
          state_d = IDLE;
        end else begin
          pop_req = 1'b1;
          lat_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!lat_done) begin
          lat_d = lat_q + LW'(1);
        end else if (!busy) begin
          data_d   = (data_q & ~bit_sel) | (bit_sel & {WIDTH{I_BIT}});
          bitcnt_d = bitcnt_q + NB'(1);
          if (bitcnt_q == NB'(WIDTH - 1)) begin
            state_d = VALID;
            nbits_d = NB'(WIDTH);
          end else begin
            state_d = IDLE;
          end
        end
      end
      VALID: begin
        if (i_ready) begin
          state_d  = IDLE;
          bitcnt_d = '0;
          data_d   = '0;
          nbits_d  = '0;
`ifdef FIFO_READER_FLUSH_EN
          partial_d = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      lat_q    <= '0;
      data_q   <= '0;
      nbits_q  <= '0;
`ifdef FIFO_READER_FLUSH_EN
      flush_q   <= '0;
      partial_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      lat_q    <= lat_d;
      data_q   <= data_d;
      nbits_q  <= nbits_d;
`ifdef FIFO_READER_FLUSH_EN
      flush_q   <= flush_d;
      partial_q <= partial_d;
`endif
    end
  end

  // pop is a decode of registered state; it is masked during reset so that
  // a reset landing in POP never reaches the FIFO.
  assign pop     = pop_req && !reset;
  assign O_DATA  = data_q;
  assign o_valid = (state_q == VALID);
  assign o_nbits = nbits_q;
`ifdef FIFO_READER_FLUSH_EN
  assign o_partial = partial_q;
`else
  assign o_partial = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_bit_reader.sv
module tb_fifo_bit_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       I_BIT = 1'b0;
  logic       empty;
  logic       busy;
  logic       pop;
  logic [7:0] O_DATA;
  logic       o_valid;
  logic       i_ready = 1'b0;
  logic       o_partial;
  logic [3:0] o_nbits;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fifo_bit_reader #(.WIDTH(8), .POP_LAT(2), .FLUSH_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .I_BIT(I_BIT), .empty(empty), .busy(busy),
    .pop(pop), .O_DATA(O_DATA), .o_valid(o_valid), .i_ready(i_ready),
    .o_partial(o_partial), .o_nbits(o_nbits)
  );

  // FIFO model: bits are written by the stimulus (src/src_wr) and consumed
  // by the model (src_rd). Data appears on I_BIT two cycles after the pop
  // cycle and stays there until the next pop result arrives.
  logic src [0:1023];
  int   src_wr = 0;
  int   src_rd = 0;
  logic s1_bit = 1'b0;
  logic s1_v = 1'b0;
  int   busy_cnt = 0;
  bit   busy_mode = 1'b0;
  int   viol = 0;

  assign empty = (src_rd == src_wr);
  assign busy  = (busy_cnt != 0);

  always @(posedge clk) begin
    if (pop && (src_rd != src_wr)) begin
      s1_bit <= src[src_rd];
      s1_v   <= 1'b1;
      src_rd <= src_rd + 1;
    end else begin
      s1_v <= 1'b0;
    end
    if (s1_v) I_BIT <= s1_bit;
    if (pop) busy_cnt <= busy_mode ? 5 : 0;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  // Illegal pops: with the FIFO empty or busy, while a word is offered, or
  // in reset.
  always @(posedge clk) begin
    if (pop && (empty || busy || o_valid || reset)) viol <= viol + 1;
  end

  task automatic push(input logic [31:0] bits, input int n);
    for (int k = 0; k < n; k++) src[src_wr + k] = bits[k];
    src_wr = src_wr + n;
  endtask

  task automatic wait_valid(input int max, output int t);
    t = -1;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (o_valid) begin
        t = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (pop !== 1'b0) begin n_bad++; $display("FAIL rst_pop: got %b expected 0", pop); end
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b expected 0", o_valid); end
    n_cmp++; if (O_DATA !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h expected 00", O_DATA); end
    n_cmp++; if (o_nbits !== 4'd0) begin n_bad++; $display("FAIL rst_nbits: got %0d expected 0", o_nbits); end
    n_cmp++; if (o_partial !== 1'b0) begin n_bad++; $display("FAIL rst_partial: got %b expected 0", o_partial); end
    reset = 1'b0;
  endtask

  // Single word 1,0,1,1,0,0,1,0 with i_ready high throughout.
  // Also used for the busy scenario: pass busy=1 and the expected latency.
  task automatic test_word(input bit with_busy, input int exp_lat, input int budget);
    int first = -1;
    int vt = -1;
    int np = 0;
    logic [7:0] dv = 8'h00;
    logic [3:0] nb = 4'd0;
    logic part = 1'b0;
    logic after = 1'b1;
    busy_mode = with_busy;
    i_ready = 1'b1;
    push(32'h4D, 8);
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (pop) begin
        np++;
        if (first < 0) first = t;
      end
      if (vt >= 0 && t == vt + 1) begin
        after = o_valid;
        break;
      end
      if (o_valid && vt < 0) begin
        vt = t; dv = O_DATA; nb = o_nbits; part = o_partial;
      end
    end
    n_cmp++; if (vt < 0 || first < 0) begin n_bad++; $display("FAIL word_timeout: got no valid (busy=%0d) expected valid", with_busy); end
    n_cmp++; if (vt - first != exp_lat) begin n_bad++; $display("FAIL word_latency: got %0d expected %0d", vt - first, exp_lat); end
    n_cmp++; if (dv !== 8'h4D) begin n_bad++; $display("FAIL word_data: got %h expected 4d", dv); end
    n_cmp++; if (nb !== 4'd8) begin n_bad++; $display("FAIL word_nbits: got %0d expected 8", nb); end
    n_cmp++; if (part !== 1'b0) begin n_bad++; $display("FAIL word_partial: got %b expected 0", part); end
    n_cmp++; if (np != 8) begin n_bad++; $display("FAIL word_pops: got %0d expected 8", np); end
    n_cmp++; if (after !== 1'b0) begin n_bad++; $display("FAIL word_valid_drop: got %b expected 0", after); end
    busy_mode = 1'b0;
  endtask

  task automatic test_back_to_back;
    int t;
    int unstable = 0;
    int np = 0;
    i_ready = 1'b0;
    push(32'h3CA5, 16);
    wait_valid(100, t);
    n_cmp++; if (t < 0) begin n_bad++; $display("FAIL bp_timeout: got no valid expected valid"); end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!o_valid || O_DATA !== 8'hA5) unstable++;
      if (pop) np++;
    end
    n_cmp++; if (unstable != 0) begin n_bad++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", unstable); end
    n_cmp++; if (np != 0) begin n_bad++; $display("FAIL bp_pops: got %0d pops expected 0", np); end
    n_cmp++; if (O_DATA !== 8'hA5) begin n_bad++; $display("FAIL bp_word1: got %h expected a5", O_DATA); end
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drop: got %b expected 0", o_valid); end
    n_cmp++; if (pop !== 1'b0) begin n_bad++; $display("FAIL bp_pop_early: got %b expected 0", pop); end
    @(negedge clk);
    n_cmp++; if (pop !== 1'b1) begin n_bad++; $display("FAIL bp_pop_resume: got %b expected 1", pop); end
    wait_valid(100, t);
    n_cmp++; if (t < 0 || O_DATA !== 8'h3C) begin n_bad++; $display("FAIL bp_word2: got %h (t=%0d) expected 3c", O_DATA, t); end
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
  endtask

`ifndef FIFO_READER_FLUSH_EN
  task automatic test_empty_hold;
    int t;
    int np = 0;
    int nv = 0;
    i_ready = 1'b1;
    push(32'h3, 3);
    for (int k = 0; k < 220; k++) begin
      @(negedge clk);
      if (pop) np++;
      if (o_valid) nv++;
    end
    n_cmp++; if (np != 3) begin n_bad++; $display("FAIL hold_pops: got %0d expected 3", np); end
    n_cmp++; if (nv != 0) begin n_bad++; $display("FAIL hold_valid: got %0d valid cycles expected 0", nv); end
    n_cmp++; if (O_DATA !== 8'h03) begin n_bad++; $display("FAIL hold_bits: got %h expected 03", O_DATA); end
    push(32'h1, 5);
    wait_valid(100, t);
    n_cmp++; if (t < 0 || O_DATA !== 8'h0B) begin n_bad++; $display("FAIL hold_word: got %h (t=%0d) expected 0b", O_DATA, t); end
    n_cmp++; if (o_nbits !== 4'd8) begin n_bad++; $display("FAIL hold_nbits: got %0d expected 8", o_nbits); end
    @(negedge clk);
  endtask
`else
  task automatic test_flush;
    int t;
    i_ready = 1'b1;
    push(32'h3, 3);
    wait_valid(300, t);
    n_cmp++; if (t < 0 || O_DATA !== 8'h03) begin n_bad++; $display("FAIL flush_data: got %h (t=%0d) expected 03", O_DATA, t); end
    n_cmp++; if (o_partial !== 1'b1) begin n_bad++; $display("FAIL flush_partial: got %b expected 1", o_partial); end
    n_cmp++; if (o_nbits !== 4'd3) begin n_bad++; $display("FAIL flush_nbits: got %0d expected 3", o_nbits); end
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid;
    int t;
    i_ready = 1'b1;
    push(32'h5, 4);
    repeat (30) @(negedge clk);
    n_cmp++; if (O_DATA !== 8'h05) begin n_bad++; $display("FAIL mid_bits: got %h expected 05", O_DATA); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (O_DATA !== 8'h00) begin n_bad++; $display("FAIL mid_rst_data: got %h expected 00", O_DATA); end
    n_cmp++; if (o_valid !== 1'b0 || pop !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ctl: got valid=%b pop=%b expected 0 0", o_valid, pop); end
    n_cmp++; if (o_nbits !== 4'd0 || o_partial !== 1'b0) begin n_bad++; $display("FAIL mid_rst_nbits: got %0d/%b expected 0/0", o_nbits, o_partial); end
    reset = 1'b0;
    push(32'hFF, 8);
    wait_valid(100, t);
    n_cmp++; if (t < 0 || O_DATA !== 8'hFF) begin n_bad++; $display("FAIL mid_word: got %h (t=%0d) expected ff", O_DATA, t); end
    n_cmp++; if (o_nbits !== 4'd8) begin n_bad++; $display("FAIL mid_nbits: got %0d expected 8", o_nbits); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_word(1'b0, 31, 100);
    test_back_to_back();
    test_word(1'b1, 63, 300);
`ifndef FIFO_READER_FLUSH_EN
    test_empty_hold();
`else
    test_flush();
`endif
    test_reset_mid();
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL pop_rules: got %0d illegal pops expected 0", viol); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
